// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: fetch state
// encoding, default geometry, the nop word and the state transition rule.
package fetch_pkg;

    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_INST_W   = 32;
    localparam int DEF_RESET_PC = 1;                  // word 0 is left empty

    // Word driven onto the decoder whenever nothing commits.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } fetch_state_e;

    // Debug-port state transition. dbg_halt outranks dbg_step, which
    // outranks dbg_run. A halt request while already halted still blocks
    // any run/step issued in the same cycle. bp_hit is only honoured while
    // running, so a single step never trips the breakpoint.
    function automatic fetch_state_e fetch_next_state(
        input fetch_state_e cur,
        input logic         dbg_halt,
        input logic         dbg_step,
        input logic         dbg_run,
        input logic         bp_hit
    );
        fetch_state_e nxt;
        nxt = HALT;
        case (cur)
            RUN: begin
                if (dbg_halt || bp_hit) nxt = HALT;
                else                    nxt = RUN;
            end
            HALT: begin
                if (dbg_halt)      nxt = HALT;
                else if (dbg_step) nxt = STEP;
                else if (dbg_run)  nxt = RUN;
                else               nxt = HALT;
            end
            STEP:    nxt = HALT;
            default: nxt = HALT;    // unreachable encoding parks the core
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (jump > branch > increment) and the
// hardware breakpoint compare against that next PC.
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              bp_hit
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] branch_pc;

    // Redirect mux; all sums wrap modulo 2^ADDR_W, and the branch offset
    // is relative to PC+1, so only its low ADDR_W bits matter.
    always_comb begin
        seq_pc    = pc + ADDR_W'(1);
        branch_pc = seq_pc + ADDR_W'(branch_off);
        if (jump)              next_pc = jump_target;
        else if (branch_taken) next_pc = branch_pc;
        else                   next_pc = seq_pc;
    end

    // Breakpoint fires on the address about to be fetched, so the
    // instruction at bp_addr is held back until the debugger resumes.
    assign bp_hit = bp_en && (next_pc == bp_addr);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address, qualifies each
// fetched word with inst_valid and gives the debugger run/halt/step control.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int INST_W       = DEF_INST_W,
    parameter int RESET_PC     = DEF_RESET_PC,
    parameter bit START_HALTED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              dbg_run,
    input  logic              dbg_step,
    input  logic              dbg_halt,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    output logic              halted,
    output logic [15:0]       icount
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    fetch_state_e      state_reg;
    logic              halted_reg;
    logic              commit_reg;   // state is RUN or STEP
    logic [ADDR_W-1:0] pc_reg;
    logic [15:0]       icount_reg;
    logic [ADDR_W-1:0] pc_next;
    logic              bp_hit;
    logic [INST_W-1:0] nop_word;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_calc (
        .pc           (pc_reg),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .next_pc      (pc_next),
        .bp_hit       (bp_hit)
    );

    // Debug FSM with registered halted/commit flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (START_HALTED) state_reg <= HALT;
            else              state_reg <= RUN;
            halted_reg <= START_HALTED;
            commit_reg <= !START_HALTED;
        end else begin
            state_reg  <= fetch_next_state(state_reg, dbg_halt, dbg_step, dbg_run, bp_hit);
            halted_reg <= (fetch_next_state(state_reg, dbg_halt, dbg_step, dbg_run, bp_hit) == HALT);
            commit_reg <= (fetch_next_state(state_reg, dbg_halt, dbg_step, dbg_run, bp_hit) != HALT);
        end
    end

    // PC and commit counter advance only on cycles where an instruction commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg     <= RESET_PC_W;
            icount_reg <= '0;
        end else if (commit_reg) begin
            pc_reg     <= pc_next;
            icount_reg <= icount_reg + 16'd1;
        end
    end

    // rst_n gates the strobe directly so an asserted reset kills the
    // current commit without waiting for the register to clear.
    assign inst_valid = commit_reg && rst_n;
    assign rom_addr   = pc_reg;
    assign pc         = pc_reg;
    assign halted     = halted_reg;
    assign icount     = icount_reg;
    assign nop_word   = INST_W'(NOP_INST);

    // Per-bit substitution of the nop word when nothing commits.
    for (genvar gi = 0; gi < INST_W; gi++) begin : g_inst_gate
        assign inst[gi] = inst_valid ? rom_inst[gi] : nop_word[gi];
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a cycle-level behavioural model
// and a per-cycle compare process.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  pc;
    logic        jump;
    logic [5:0]  jump_target;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        dbg_run, dbg_step, dbg_halt;
    logic        bp_en;
    logic [5:0]  bp_addr;
    logic        halted;
    logic [15:0] icount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Standard program: add, ori, store, load, beq -4, jump 1.
    function automatic logic [31:0] rom_word(input int a);
        case (a)
            0:       return 32'h0000_0000;
            1:       return 32'h0022_1820;
            2:       return 32'h3443_0005;
            3:       return 32'hAC03_0010;
            4:       return 32'h8C04_0010;
            5:       return 32'h1000_FFFC;
            6:       return 32'h0800_0001;
            default: return 32'hA000_0000 | 32'(a);
        endcase
    endfunction

    assign rom_inst = rom_word(int'(rom_addr));

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .dbg_run      (dbg_run),
        .dbg_step     (dbg_step),
        .dbg_halt     (dbg_halt),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .halted       (halted),
        .icount       (icount)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pc       = 1;
    bit m_running  = 1'b1;
    bit m_stepping = 1'b0;
    int m_icount   = 0;
    int m_np;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc       = 1;
            m_running  = 1'b1;
            m_stepping = 1'b0;
            m_icount   = 0;
        end else begin
            if (m_running || m_stepping) begin
                if (jump)
                    m_np = int'(jump_target);
                else if (branch_taken)
                    m_np = ((m_pc + 1 + int'($signed(branch_off))) % 64 + 64) % 64;
                else
                    m_np = (m_pc + 1) % 64;
                m_icount = (m_icount + 1) % 65536;
            end else begin
                m_np = m_pc;
            end
            if (m_running) begin
                if (dbg_halt || (bp_en && m_np == int'(bp_addr))) m_running = 1'b0;
            end else if (m_stepping) begin
                m_stepping = 1'b0;
            end else begin
                if (dbg_halt)      m_running = 1'b0;
                else if (dbg_step) m_stepping = 1'b1;
                else if (dbg_run)  m_running = 1'b1;
            end
            m_pc = m_np;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit    exp_valid;
        exp_valid = rst_n && (m_running || m_stepping);
        chk("cyc_rom_addr", rom_addr, m_pc);
        chk("cyc_pc", pc, m_pc);
        chk("cyc_valid", inst_valid, exp_valid);
        chk("cyc_inst", inst, exp_valid ? rom_word(m_pc) : 32'h0);
        chk("cyc_halted", halted, !(m_running || m_stepping));
        chk("cyc_icount", icount, m_icount);
        if (inst_valid)
            $display("[TB] commit pc=%0d inst=%08h icount=%0d", pc, inst, icount);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b1; jump = 1'b0; jump_target = '0; branch_taken = 1'b0;
        branch_off = '0; dbg_run = 1'b0; dbg_step = 1'b0; dbg_halt = 1'b0;
        bp_en = 1'b0; bp_addr = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rom_addr", rom_addr, 1);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_icount", icount, 0);
        chk("rst_halted", halted, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("run_pc1", pc, 1);
        chk("run_valid1", inst_valid, 1);
        chk("run_inst1", inst, 32'h0022_1820);

        // Straight-line fetch, then taken branch at word 5 back to 2
        repeat (4) cyc();
        chk("seq_pc5", pc, 5);
        chk("seq_icount4", icount, 4);
        branch_taken = 1'b1; branch_off = 16'hFFFC;
        cyc();
        branch_taken = 1'b0;
        chk("br_back_pc2", pc, 2);
        cyc();
        chk("icount6", icount, 6);
        repeat (2) cyc();
        chk("nt_pc5", pc, 5);
        cyc();
        chk("nt_pc6", pc, 6);
        jump = 1'b1; jump_target = 6'd1;
        cyc();
        jump = 1'b0;
        chk("jump_pc1", pc, 1);

        // Jump beats branch
        repeat (4) cyc();
        jump = 1'b1; jump_target = 6'd1; branch_taken = 1'b1; branch_off = 16'hFFFC;
        cyc();
        jump = 1'b0; branch_taken = 1'b0;
        chk("jump_prio_pc1", pc, 1);

        // Wrap at the top of the address space, negative branch wraps below 0
        jump = 1'b1; jump_target = 6'd63;
        cyc();
        jump = 1'b0;
        chk("pc63", pc, 63);
        cyc();
        chk("wrap_pc0", pc, 0);
        cyc();
        branch_taken = 1'b1; branch_off = 16'hFFFD;
        cyc();
        branch_taken = 1'b0;
        chk("neg_wrap_pc63", pc, 63);
        repeat (2) cyc();

        // Breakpoint at word 4, then resume without re-trigger
        bp_en = 1'b1; bp_addr = 6'd4;
        repeat (3) cyc();
        chk("bp_halted", halted, 1);
        chk("bp_rom_addr", rom_addr, 4);
        chk("bp_valid", inst_valid, 0);
        chk("bp_inst", inst, 0);
        repeat (2) cyc();
        dbg_run = 1'b1;
        cyc();
        dbg_run = 1'b0;
        chk("resume_valid", inst_valid, 1);
        chk("resume_inst4", inst, 32'h8C04_0010);
        cyc();
        chk("resume_pc5", pc, 5);
        chk("resume_no_rehalt", halted, 0);
        bp_en = 1'b0;

        // Halt at word 2 (branch commits with the halt), single step, blocked run
        branch_taken = 1'b1; branch_off = 16'hFFFC; dbg_halt = 1'b1;
        cyc();
        branch_taken = 1'b0; dbg_halt = 1'b0;
        chk("halt_pc2", pc, 2);
        chk("halt_flag", halted, 1);
        dbg_step = 1'b1;
        cyc();
        dbg_step = 1'b0;
        chk("step_valid", inst_valid, 1);
        chk("step_halted0", halted, 0);
        cyc();
        chk("step_pc3", pc, 3);
        chk("step_rehalt", halted, 1);
        chk("step_once", inst_valid, 0);
        dbg_halt = 1'b1; dbg_run = 1'b1;
        cyc();
        dbg_halt = 1'b0; dbg_run = 1'b0;
        chk("halt_beats_run", halted, 1);
        dbg_run = 1'b1;
        cyc();
        dbg_run = 1'b0;
        chk("run_again_valid", inst_valid, 1);
        repeat (2) cyc();
        chk("run_again_pc5", pc, 5);

        // Mid-run reset aborts immediately
        rst_n = 1'b0;
        #1;
        chk("abort_pc1", pc, 1);
        chk("abort_valid", inst_valid, 0);
        chk("abort_icount", icount, 0);
        chk("abort_inst", inst, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_pc1", pc, 1);
        chk("post_rst_valid", inst_valid, 1);
        cyc();
        chk("post_rst_pc2", pc, 2);
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
